// File: rtl/step_key_conditioner.sv
// rtl/step_key_conditioner.sv - synchronise, debounce and strobe three step keys; optional PRESS_COUNT_EN
module step_key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       CLOCK,
   input  logic       reset,
   input  logic       KEY_enter_n,
   input  logic       KEY_sendS_n,
   input  logic       KEY_recvR_n,
   output logic       enter,
   output logic       send_confirmS,
   output logic       send_confirmR,
   output logic       enter_pulse,
   output logic       sendS_pulse,
   output logic       recvR_pulse
`ifdef PRESS_COUNT_EN
   ,
   output logic [7:0] press_count
`endif
);

   localparam logic [1:0] ST_RELEASED     = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channel order throughout: bit 0 = enter, bit 1 = send-confirm, bit 2 = receive-confirm.
   logic [2:0]       w_pressed;
   logic [2:0]       r_s1;
   logic [2:0]       r_s2;
   logic [2:0]       r_level;
   logic [2:0]       r_pulse;
   logic [1:0]       r_state [3];
   logic [CNT_W-1:0] r_cnt   [3];

   assign w_pressed = ~{KEY_recvR_n, KEY_sendS_n, KEY_enter_n};

   // Two-flop synchroniser for the asynchronous, inverted key inputs
   always_ff @(posedge CLOCK) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_pressed;
         r_s2 <= r_s1;
      end
   end

   // Per-channel debounce FSM; level and pulse are registered alongside the state
   always_ff @(posedge CLOCK) begin
      if (reset) begin
         r_level <= '0;
         r_pulse <= '0;
         for (int i = 0; i < 3; i++) begin
            r_state[i] <= ST_RELEASED;
            r_cnt[i]   <= '0;
         end
      end else begin
         r_pulse <= '0;
         for (int i = 0; i < 3; i++) begin
            case (r_state[i])
               ST_RELEASED: begin
                  if (r_s2[i]) begin
                     r_state[i] <= ST_PRESS_WAIT;
                     r_cnt[i]   <= '0;
                  end
               end
               ST_PRESS_WAIT: begin
                  if (!r_s2[i]) begin
                     r_state[i] <= ST_RELEASED;
                  end else if (r_cnt[i] == TERM_CNT) begin
                     r_state[i] <= ST_PRESSED;
                     r_level[i] <= 1'b1;
                     r_pulse[i] <= 1'b1;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + 1'b1;
                  end
               end
               ST_PRESSED: begin
                  if (!r_s2[i]) begin
                     r_state[i] <= ST_RELEASE_WAIT;
                     r_cnt[i]   <= '0;
                  end
               end
               default: begin
                  // Release wait: a short return to pressed is a glitch, level stays high
                  if (r_s2[i]) begin
                     r_state[i] <= ST_PRESSED;
                  end else if (r_cnt[i] == TERM_CNT) begin
                     r_state[i] <= ST_RELEASED;
                     r_level[i] <= 1'b0;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign enter         = r_level[0];
   assign send_confirmS = r_level[1];
   assign send_confirmR = r_level[2];
   assign enter_pulse   = r_pulse[0];
   assign sendS_pulse   = r_pulse[1];
   assign recvR_pulse   = r_pulse[2];

`ifdef PRESS_COUNT_EN
   logic [7:0] r_press_count;

   // Count accepted enter presses, wrapping naturally at 8 bits
   always_ff @(posedge CLOCK) begin
      if (reset) begin
         r_press_count <= '0;
      end else if (r_pulse[0]) begin
         r_press_count <= r_press_count + 8'd1;
      end
   end

   assign press_count = r_press_count;
`endif

endmodule

// File: tb/tb_step_key_conditioner.sv
// tb/tb_step_key_conditioner.sv - directed self-checking bench for step_key_conditioner
module tb_step_key_conditioner;

   logic CLOCK = 1'b0;
   logic reset = 1'b1;
   logic KEY_enter_n = 1'b1;
   logic KEY_sendS_n = 1'b1;
   logic KEY_recvR_n = 1'b1;
   logic enter, send_confirmS, send_confirmR;
   logic enter_pulse, sendS_pulse, recvR_pulse;
`ifdef PRESS_COUNT_EN
   logic [7:0] press_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   step_key_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .CLOCK         (CLOCK),
      .reset         (reset),
      .KEY_enter_n   (KEY_enter_n),
      .KEY_sendS_n   (KEY_sendS_n),
      .KEY_recvR_n   (KEY_recvR_n),
      .enter         (enter),
      .send_confirmS (send_confirmS),
      .send_confirmR (send_confirmR),
      .enter_pulse   (enter_pulse),
      .sendS_pulse   (sendS_pulse),
      .recvR_pulse   (recvR_pulse)
`ifdef PRESS_COUNT_EN
      ,
      .press_count   (press_count)
`endif
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit past the last edge
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   int hi_cnt;
   int pulse_cnt;
   int waited;

   initial begin
      // Reset with all keys held pressed
      KEY_enter_n = 1'b0; KEY_sendS_n = 1'b0; KEY_recvR_n = 1'b0;
      reset = 1'b1;
      tick(1);
      check("rst_levels_c1", {enter, send_confirmS, send_confirmR}, 0);
      check("rst_pulses_c1", {enter_pulse, sendS_pulse, recvR_pulse}, 0);
      tick(1);
      check("rst_levels_c2", {enter, send_confirmS, send_confirmR}, 0);
      check("rst_pulses_c2", {enter_pulse, sendS_pulse, recvR_pulse}, 0);
      reset = 1'b0;
      tick(6);
      check("rst_enter_e6", enter, 0);
      tick(1);
      check("rst_enter_e7", enter, 1);
      check("par_pulses_e7", {enter_pulse, sendS_pulse, recvR_pulse}, 3'b111);
      tick(1);
      check("par_pulses_e8", {enter_pulse, sendS_pulse, recvR_pulse}, 0);
      check("par_levels_e8", {enter, send_confirmS, send_confirmR}, 3'b111);
      KEY_enter_n = 1'b1; KEY_sendS_n = 1'b1; KEY_recvR_n = 1'b1;
      tick(6);
      check("rel_all_e6", {enter, send_confirmS, send_confirmR}, 3'b111);
      tick(1);
      check("rel_all_e7", {enter, send_confirmS, send_confirmR}, 0);
      tick(4);

      // Clean enter press: 20 cycles low, then released
      KEY_enter_n = 1'b0;
      tick(6);
      check("clean_enter_e6", enter, 0);
      check("clean_pulse_e6", enter_pulse, 0);
      tick(1);
      check("clean_enter_e7", enter, 1);
      check("clean_pulse_e7", enter_pulse, 1);
      tick(1);
      check("clean_pulse_e8", enter_pulse, 0);
      pulse_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         pulse_cnt += enter_pulse;
      end
      check("clean_hold_pulses", pulse_cnt, 0);
      check("clean_hold_level", enter, 1);
      KEY_enter_n = 1'b1;
      pulse_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         pulse_cnt += enter_pulse;
      end
      check("clean_rel_e6", enter, 1);
      tick(1);
      check("clean_rel_e7", enter, 0);
      pulse_cnt += enter_pulse;
      check("clean_rel_no_pulse", pulse_cnt, 0);
      tick(4);

      // Bounce on send-confirm: low 3, high 2, low 3, high
      hi_cnt = 0;
      pulse_cnt = 0;
      for (int k = 0; k < 24; k++) begin
         if (k < 3 || (k >= 5 && k < 8)) KEY_sendS_n = 1'b0;
         else KEY_sendS_n = 1'b1;
         tick(1);
         hi_cnt += send_confirmS;
         pulse_cnt += sendS_pulse;
      end
      check("bounce_level", hi_cnt, 0);
      check("bounce_pulse", pulse_cnt, 0);

      // Release glitch on receive-confirm
      KEY_recvR_n = 1'b0;
      pulse_cnt = 0;
      waited = 0;
      while (send_confirmR !== 1'b1 && waited < 20) begin
         tick(1);
         waited++;
         pulse_cnt += recvR_pulse;
      end
      check("glitch_press_seen", send_confirmR, 1);
      check("glitch_first_pulse", pulse_cnt, 1);
      tick(1);
      KEY_recvR_n = 1'b1;
      tick(2);
      KEY_recvR_n = 1'b0;
      hi_cnt = 0;
      pulse_cnt = 0;
      for (int k = 0; k < 15; k++) begin
         tick(1);
         hi_cnt += !send_confirmR;
         pulse_cnt += recvR_pulse;
      end
      check("glitch_level_drops", hi_cnt, 0);
      check("glitch_extra_pulse", pulse_cnt, 0);
      KEY_recvR_n = 1'b1;
      tick(10);
      check("glitch_final_rel", send_confirmR, 0);

      // Reset during PRESS_WAIT cycle 2 (after edge 4), then re-debounce
      KEY_enter_n = 1'b0;
      tick(4);
      reset = 1'b1;
      tick(1);
      check("midrst_level", enter, 0);
      check("midrst_pulse", enter_pulse, 0);
      reset = 1'b0;
      pulse_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         pulse_cnt += enter_pulse;
      end
      check("midrst_no_early_pulse", pulse_cnt, 0);
      check("midrst_e6", enter, 0);
      tick(1);
      check("midrst_e7_level", enter, 1);
      check("midrst_e7_pulse", enter_pulse, 1);

      // Reset while PRESSED drops the level on the reset edge
      tick(3);
      reset = 1'b1;
      tick(1);
      check("rst_pressed_level", enter, 0);
      KEY_enter_n = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(4);

`ifdef PRESS_COUNT_EN
      check("cnt_after_reset", press_count, 0);
      for (int p = 0; p < 257; p++) begin
         KEY_enter_n = 1'b0;
         tick(8);
         KEY_enter_n = 1'b1;
         tick(8);
      end
      check("cnt_257_presses", press_count, 1);
      KEY_sendS_n = 1'b0;
      tick(8);
      KEY_sendS_n = 1'b1;
      tick(8);
      check("cnt_other_key", press_count, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/step_key_conditioner.md
# step_key_conditioner

Conditions the three raw push-button inputs that drive manual stepping of the processor clock: the enter key, the send-confirm key and the receive-confirm key. It sits directly upstream of the clock-source selector. Each raw key is synchronised, debounced and turned into a clean level plus a single-cycle press pulse. The clean levels feed the selector's `enter`, `send_confirmS` and `send_confirmR` inputs, so one physical press produces exactly one clean rising edge of the processor clock.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: stable cycles required before a level change is accepted (10 ms at 50 MHz). Must be ≥ 2.
- `CNT_W`, default 20: debounce counter width. Must hold `DEBOUNCE_CYCLES-1`.
- `CLOCK` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `KEY_enter_n` in 1: raw enter key, active-low, asynchronous.
- `KEY_sendS_n` in 1: raw send-confirm key, active-low, asynchronous.
- `KEY_recvR_n` in 1: raw receive-confirm key, active-low, asynchronous.
- `enter` out 1: debounced enter level, 1 = pressed.
- `send_confirmS` out 1: debounced send-confirm level.
- `send_confirmR` out 1: debounced receive-confirm level.
- `enter_pulse`, `sendS_pulse`, `recvR_pulse` out 1 each: one-cycle strobe on an accepted press.
- `press_count` out 8: present only with `PRESS_COUNT_EN` (see Configuration).

## Operation
- Three identical, fully independent channels. There is no priority or interaction between keys.
- Per channel, input handling:
  - Raw input is inverted, so pressed = 1.
  - It then passes through a 2-FF synchroniser `s1 -> s2`. Both flops reset to 0.
- Per channel FSM, with a `CNT_W`-bit counter `cnt`:
  - RELEASED: level = 0.
    - `s2==1` -> PRESS_WAIT, `cnt<=0`.
  - PRESS_WAIT: level = 0.
    - `s2==0` -> RELEASED. The bounce is rejected and no output changes.
    - Else if `cnt==DEBOUNCE_CYCLES-1` -> PRESSED, level <= 1, pulse <= 1.
    - Else `cnt<=cnt+1`.
  - PRESSED: level = 1.
    - `s2==0` -> RELEASE_WAIT, `cnt<=0`.
  - RELEASE_WAIT: level = 1.
    - `s2==1` -> PRESSED. The glitch is rejected: no pulse, level unchanged.
    - Else if `cnt==DEBOUNCE_CYCLES-1` -> RELEASED, level <= 0.
    - Else `cnt<=cnt+1`.
- Pulse is registered:
  - High for exactly the one cycle following the PRESS_WAIT -> PRESSED transition.
  - Otherwise 0.
  - No pulse is generated on release.
- Level and pulse are registered outputs, not decoded combinationally from state.
- Counter never wraps; it is bounded by the compare against `DEBOUNCE_CYCLES-1`.

## Timing
- Reset (synchronous, `reset==1` at a rising edge):
  - All states go to RELEASED; `cnt`, `s1`, `s2` go to 0.
  - All level and pulse outputs go to 0.
  - `press_count` goes to 0.
- Press latency: with the raw key held pressed from before edge 1, the level and pulse go high after edge `DEBOUNCE_CYCLES+3`:
  - edges 1–2: synchroniser;
  - edge 3: enter PRESS_WAIT;
  - `DEBOUNCE_CYCLES` further edges to reach and pass the terminal count.
- Release latency: symmetric, the level falls after edge `DEBOUNCE_CYCLES+3`.
- Glitch rejection:
  - Any excursion shorter than `DEBOUNCE_CYCLES+1` cycles, as seen at `s2`, is rejected.
  - After a rejected press the counter restarts from 0 on the next excursion.
- Reset mid-operation:
  - Reset overrides any state, including PRESSED, and the level drops on the reset edge.
  - A key still held after reset deasserts is re-debounced from scratch: the level rises `DEBOUNCE_CYCLES+3` edges after the first non-reset edge.
- Simultaneous presses on several keys are processed in parallel with identical latency.

## Configuration
- Macro `PRESS_COUNT_EN`.
- Defined:
  - Port `press_count[7:0]` exists.
  - It increments by 1 on each `enter_pulse` and wraps 255 -> 0.
  - It resets to 0.
  - It is not affected by the other keys.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4`, `CNT_W=3`.
- Reset: assert `reset` for 2 cycles with all keys held pressed -> all levels and pulses read 0 during reset; `enter` rises 7 edges after the first non-reset edge.
- Clean press: `KEY_enter_n` low for 20 cycles, then high -> `enter` and `enter_pulse` go high on edge 7; the pulse lasts exactly 1 cycle; `enter` falls 7 edges after release.
- Bounce: `KEY_sendS_n` low for 3 cycles, high for 2, low for 3, then high -> `send_confirmS` and `sendS_pulse` stay 0 throughout.
- Release glitch: hold `KEY_recvR_n` pressed until `send_confirmR==1`, then high for 2 cycles, then low again -> `send_confirmR` stays 1 and no second `recvR_pulse` occurs.
- Parallel and mid-operation reset:
  - All three keys pressed on the same cycle -> all three pulses fire on the same edge.
  - `reset` asserted on PRESS_WAIT cycle 2 -> no pulse, and the count restarts after reset.
- With `PRESS_COUNT_EN` defined, 257 clean enter presses -> `press_count==1`.
